control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Hard-wired Moore control sequencer for the single-bus CPU datapath; drives every datapath
//  control strobe that benches currently hand-drive, one step (T-state) per Clock.
//  Fetches at PC, decodes IR[31:27], sequences execute steps, handles halt/stop.
//  Sits beside Datapath_P2: consumes IR and BranchMet, produces its control inputs.
// PARAMETERS
//  OPW      5   opcode field width, IR[31:27]
//  ALUOPW   4   width of alu_op select
// PORTS
//  Clock            in   1   system clock; all state changes on posedge
//  Clear            in   1   asynchronous, active-low reset
//  IR               in   32  instruction register contents (valid from end of T2)
//  BranchMet        in   1   CON FF output from datapath
//  Stop             in   1   halt request, sampled only at instruction boundary
//  Run              out  1   1 while executing, 0 in RESET/HALT
//  PCout,Zhiout,Zlowout,MDRout,HIout,LOout,InPortout,BAout,Cout  out 1 each  bus drivers
//  PCin,MARin,MDRin,IRin,Yin,Zin,HIin,LOin,OutPortin,CONIn        out 1 each  reg loads
//  IncPC,Read,Write  out 1 each  PC incr / memory read / memory write
//  Gra,Grb,Grc,Rin,Rout  out 1 each  register-select and GPR strobes
//  alu_op           out  ALUOPW  ALU function (cu_pkg encoding; ADD default)
// BEHAVIOUR
//  - State reg: RESET,T0..T7,HALT. Outputs purely decoded from state+IR+BranchMet (Moore);
//    stable all cycle, captured by datapath at next posedge. Every strobe 0 outside its step.
//  - Clear low (any time, incl. mid-instruction): state=RESET at once, all strobes 0, Run=0,
//    alu_op=ADD. First posedge after release: RESET->T0.
//  - Fetch: T0 PCout MARin IncPC Zin; T1 Zlowout PCin Read MDRin; T2 MDRout IRin.
//  - Execute (last listed step returns to T0; Stop=1 there -> HALT instead):
//    add/sub/and/or: T3 Grb Rout Yin; T4 Grc Rout alu_op Zin; T5 Zlowout Gra Rin.
//    addi/andi/ori:  T3 Grb Rout Yin; T4 Cout alu_op Zin; T5 Zlowout Gra Rin.
//    ldi: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin.
//    ld:  T3-T4 as ldi; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
//    st:  T3-T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
//    br:  T3 Gra Rout CONIn; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout&PCin iff BranchMet.
//    jr: T3 Gra Rout PCin. jal: T3 PCout Grb Rin (link); T4 Gra Rout PCin.
//    in: T3 InPortout Gra Rin. out: T3 Gra Rout OutPortin. mfhi/mflo: T3 HIout|LOout Gra Rin.
//    nop and undefined opcodes: T3 no strobes. halt: T3 -> HALT.
//  - HALT: all strobes 0, Run=0; left only by Clear. Stop outside boundary has no effect.
//  - alu_op = per-opcode function in its ALU step; ADD in every other state.
// CONFIGURATION
//  MUL_DIV_EN defined: mul/div decoded: T3 Gra Rout Yin; T4 Grb Rout alu_op(MUL|DIV) Zin;
//    T5 Zlowout LOin; T6 Zhiout HIin. Not defined: mul/div opcodes execute as nop.
// STRUCTURE
//  cu_pkg: opcode localparams (ld 00000, ldi 00001, st 00010, add 00011, sub 00100,
//    and 00101, or 00110, addi 01010, andi 01011, ori 01100, mul 01111, div 10000,
//    br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000,
//    nop 11001, halt 11010), state encodings, alu_op encodings.
//  Single module; no sub-module (decode is a flat case on state x opcode).
// TESTING
//  - Clear low 2 cycles, release -> RESET then T0 with PCout=MARin=IncPC=Zin=1, Run=1.
//  - IR=0x590FFFFB (andi R2,R1,-5) -> T3 Grb Rout Yin; T4 Cout Zin alu_op=AND;
//    T5 Zlowout Gra Rin; T0 next cycle.
//  - ld IR=0x00800004 -> 8 steps T0..T7; Read=1 in T1 and T6 only; MDRout Gra Rin in T7.
//  - br with BranchMet=0 then =1 -> T6 PCin=0 resp. PCin=Zlowout=1; both return to T0.
//  - Stop=1 during add T4 ignored; held through T5 -> HALT, Run=0, strobes 0 for 10 cycles.
//  - Clear low in ld T6 -> Read/MDRin drop same time, RESET; mul opcode: nop w/o MUL_DIV_EN,
//    LOin in T5 / HIin in T6 with it.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the control_unit sequencer.
//
// Contents:
//   - field widths (OPW opcode, ALUOPW ALU select, STW state register)
//   - opcode encodings for IR[31:27]
//   - state encodings (RESET, T0..T7, HALT)
//   - alu_op encodings seen by the datapath ALU
//   - op_class_e: opcodes grouped by identical step sequences
//   - ctrl_t: bundle of every datapath strobe
//   - helpers: classify(), alu_fn(), last_step()
//
// Configuration: when MUL_DIV_EN is defined, mul/div are classified as
// CLS_MULDIV. Otherwise they fall through to CLS_NOP.

package cu_pkg;

  localparam int OPW    = 5;
  localparam int ALUOPW = 4;
  localparam int STW    = 4;

  // Opcodes (IR[31:27])
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01010;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01011;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01100;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
  localparam logic [OPW-1:0] OP_IN   = 5'b10101;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  // Sequencer states
  localparam logic [STW-1:0] ST_RESET = 4'd0;
  localparam logic [STW-1:0] ST_T0    = 4'd1;
  localparam logic [STW-1:0] ST_T1    = 4'd2;
  localparam logic [STW-1:0] ST_T2    = 4'd3;
  localparam logic [STW-1:0] ST_T3    = 4'd4;
  localparam logic [STW-1:0] ST_T4    = 4'd5;
  localparam logic [STW-1:0] ST_T5    = 4'd6;
  localparam logic [STW-1:0] ST_T6    = 4'd7;
  localparam logic [STW-1:0] ST_T7    = 4'd8;
  localparam logic [STW-1:0] ST_HALT  = 4'd9;

  // ALU function select
  localparam logic [ALUOPW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOPW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOPW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOPW-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUOPW-1:0] ALU_MUL = 4'd4;
  localparam logic [ALUOPW-1:0] ALU_DIV = 4'd5;

  // Opcodes that share one step sequence share one class.
  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ALU_REG,
    CLS_ALU_IMM,
    CLS_LDI,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_JR,
    CLS_JAL,
    CLS_IN,
    CLS_OUT,
    CLS_MFHI,
    CLS_MFLO,
    CLS_HALT,
    CLS_MULDIV
  } op_class_e;

  typedef struct packed {
    logic pc_out;
    logic zhi_out;
    logic zlow_out;
    logic mdr_out;
    logic hi_out;
    logic lo_out;
    logic inport_out;
    logic ba_out;
    logic c_out;
    logic pc_in;
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic outport_in;
    logic con_in;
    logic inc_pc;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } ctrl_t;

  function automatic op_class_e classify(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_ALU_REG;
      OP_ADDI, OP_ANDI, OP_ORI:      return CLS_ALU_IMM;
      OP_LDI:                        return CLS_LDI;
      OP_LD:                         return CLS_LD;
      OP_ST:                         return CLS_ST;
      OP_BR:                         return CLS_BR;
      OP_JR:                         return CLS_JR;
      OP_JAL:                        return CLS_JAL;
      OP_IN:                         return CLS_IN;
      OP_OUT:                        return CLS_OUT;
      OP_MFHI:                       return CLS_MFHI;
      OP_MFLO:                       return CLS_MFLO;
      OP_HALT:                       return CLS_HALT;
`ifdef MUL_DIV_EN
      OP_MUL, OP_DIV:                return CLS_MULDIV;
`endif
      default:                       return CLS_NOP;  // nop and undefined opcodes
    endcase
  endfunction

  // ALU function used in an opcode's ALU step.
  function automatic logic [ALUOPW-1:0] alu_fn(input logic [OPW-1:0] op);
    case (op)
      OP_SUB:         return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:  return ALU_OR;
      OP_MUL:         return ALU_MUL;
      OP_DIV:         return ALU_DIV;
      default:        return ALU_ADD;
    endcase
  endfunction

  // Final execute step of each class. This is the instruction boundary,
  // where Stop is sampled.
  function automatic logic [STW-1:0] last_step(input op_class_e cls);
    case (cls)
      CLS_ALU_REG, CLS_ALU_IMM, CLS_LDI: return ST_T5;
      CLS_LD, CLS_ST:                    return ST_T7;
      CLS_BR, CLS_MULDIV:                return ST_T6;
      CLS_JAL:                           return ST_T4;
      default:                           return ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: hard-wired Moore sequencer for the single-bus CPU datapath.
//
// Operation:
//   - One T-state per Clock.
//   - Fetch occupies T0..T2.
//   - Execute runs T3 up to the opcode's last step, then returns to T0.
//     If Stop is high at that last step, the sequencer goes to HALT instead.
//   - The halt opcode enters HALT directly from T3.
//   - All outputs are decoded combinationally from state, IR and BranchMet.
//
// Ports:
//   Clock      in   system clock, posedge active
//   Clear      in   asynchronous active-low reset (state -> RESET)
//   IR         in   instruction register; opcode in IR[31:27], used from T3
//   BranchMet  in   CON flip-flop from the datapath
//   Stop       in   halt request, honoured only at the instruction boundary
//   Run        out  high in T0..T7
//   PCout..Cout, PCin..CONIn, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout
//              out  datapath strobes; each is 0 outside its step
//   alu_op     out  ALU function; ADD except in an ALU step
//
// Configuration: define MUL_DIV_EN to decode mul/div. Otherwise both
// execute as nop.

module control_unit
  import cu_pkg::*;
(
  input  logic              Clock,
  input  logic              Clear,
  input  logic [31:0]       IR,
  input  logic              BranchMet,
  input  logic              Stop,
  output logic              Run,
  output logic              PCout,
  output logic              Zhiout,
  output logic              Zlowout,
  output logic              MDRout,
  output logic              HIout,
  output logic              LOout,
  output logic              InPortout,
  output logic              BAout,
  output logic              Cout,
  output logic              PCin,
  output logic              MARin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              HIin,
  output logic              LOin,
  output logic              OutPortin,
  output logic              CONIn,
  output logic              IncPC,
  output logic              Read,
  output logic              Write,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic [ALUOPW-1:0] alu_op
);

  logic [STW-1:0]    state;
  logic [STW-1:0]    next_state;
  logic [OPW-1:0]    opcode;
  op_class_e         cls;
  logic [STW-1:0]    final_step;
  logic [ALUOPW-1:0] alu_sel;
  ctrl_t             ctrl;
  logic              unused_ir;

  assign opcode     = IR[31:27];
  assign cls        = classify(opcode);
  assign final_step = last_step(cls);
  assign alu_sel    = alu_fn(opcode);

  // Register and immediate fields are decoded by the datapath, not here.
  assign unused_ir  = ^IR[26:0];

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the edge.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= ST_RESET;
    else        state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_RESET: next_state = ST_T0;
      ST_T0:    next_state = ST_T1;
      ST_T1:    next_state = ST_T2;
      ST_T2:    next_state = ST_T3;
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (cls == CLS_HALT)          next_state = ST_HALT;
        else if (state == final_step) next_state = Stop ? ST_HALT : ST_T0;
        else                          next_state = state + STW'(1);
      end
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_RESET;  // unused codes recover via RESET
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    case (state)
      ST_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
      end
      ST_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end

      ST_T3: begin
        case (cls)
          CLS_ALU_REG, CLS_ALU_IMM: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            // BAout drives 0 when Rb is R0, giving absolute addressing.
            ctrl.grb    = 1'b1;
            ctrl.ba_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          CLS_BR: begin
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.con_in = 1'b1;
          end
          CLS_JR: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_in = 1'b1;
          end
          CLS_JAL: begin
            // Link first: PC (already incremented) goes to Rb.
            ctrl.pc_out = 1'b1;
            ctrl.grb    = 1'b1;
            ctrl.r_in   = 1'b1;
          end
          CLS_IN: begin
            ctrl.inport_out = 1'b1;
            ctrl.gra        = 1'b1;
            ctrl.r_in       = 1'b1;
          end
          CLS_OUT: begin
            ctrl.gra        = 1'b1;
            ctrl.r_out      = 1'b1;
            ctrl.outport_in = 1'b1;
          end
          CLS_MFHI: begin
            ctrl.hi_out = 1'b1;
            ctrl.gra    = 1'b1;
            ctrl.r_in   = 1'b1;
          end
          CLS_MFLO: begin
            ctrl.lo_out = 1'b1;
            ctrl.gra    = 1'b1;
            ctrl.r_in   = 1'b1;
          end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
`endif
          default: ;  // nop, halt, undefined: no strobes
        endcase
      end

      ST_T4: begin
        case (cls)
          CLS_ALU_REG: begin
            ctrl.grc   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.z_in  = 1'b1;
            alu_op     = alu_sel;
          end
          CLS_ALU_IMM: begin
            ctrl.c_out = 1'b1;
            ctrl.z_in  = 1'b1;
            alu_op     = alu_sel;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            // Effective address is always base + offset.
            ctrl.c_out = 1'b1;
            ctrl.z_in  = 1'b1;
          end
          CLS_BR: begin
            ctrl.pc_out = 1'b1;
            ctrl.y_in   = 1'b1;
          end
          CLS_JAL: begin
            ctrl.gra   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.pc_in = 1'b1;
          end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.z_in  = 1'b1;
            alu_op     = alu_sel;
          end
`endif
          default: ;
        endcase
      end

      ST_T5: begin
        case (cls)
          CLS_ALU_REG, CLS_ALU_IMM, CLS_LDI: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl.zlow_out = 1'b1;
            ctrl.mar_in   = 1'b1;
          end
          CLS_BR: begin
            // Branch target = PC + C.
            ctrl.c_out = 1'b1;
            ctrl.z_in  = 1'b1;
          end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin
            ctrl.zlow_out = 1'b1;
            ctrl.lo_in    = 1'b1;
          end
`endif
          default: ;
        endcase
      end

      ST_T6: begin
        case (cls)
          CLS_LD: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          CLS_ST: begin
            // MDR loads from the bus here, so Read stays low.
            ctrl.gra    = 1'b1;
            ctrl.r_out  = 1'b1;
            ctrl.mdr_in = 1'b1;
          end
          CLS_BR: begin
            ctrl.zlow_out = BranchMet;
            ctrl.pc_in    = BranchMet;
          end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin
            ctrl.zhi_out = 1'b1;
            ctrl.hi_in   = 1'b1;
          end
`endif
          default: ;
        endcase
      end

      ST_T7: begin
        case (cls)
          CLS_LD: begin
            ctrl.mdr_out = 1'b1;
            ctrl.gra     = 1'b1;
            ctrl.r_in    = 1'b1;
          end
          CLS_ST: ctrl.write = 1'b1;
          default: ;
        endcase
      end

      default: ;  // RESET, HALT, unused codes: everything idle
    endcase
  end

  assign Run       = (state >= ST_T0) && (state <= ST_T7);
  assign PCout     = ctrl.pc_out;
  assign Zhiout    = ctrl.zhi_out;
  assign Zlowout   = ctrl.zlow_out;
  assign MDRout    = ctrl.mdr_out;
  assign HIout     = ctrl.hi_out;
  assign LOout     = ctrl.lo_out;
  assign InPortout = ctrl.inport_out;
  assign BAout     = ctrl.ba_out;
  assign Cout      = ctrl.c_out;
  assign PCin      = ctrl.pc_in;
  assign MARin     = ctrl.mar_in;
  assign MDRin     = ctrl.mdr_in;
  assign IRin      = ctrl.ir_in;
  assign Yin       = ctrl.y_in;
  assign Zin       = ctrl.z_in;
  assign HIin      = ctrl.hi_in;
  assign LOin      = ctrl.lo_in;
  assign OutPortin = ctrl.outport_in;
  assign CONIn     = ctrl.con_in;
  assign IncPC     = ctrl.inc_pc;
  assign Read      = ctrl.read;
  assign Write     = ctrl.write;
  assign Gra       = ctrl.gra;
  assign Grb       = ctrl.grb;
  assign Grc       = ctrl.grc;
  assign Rin       = ctrl.r_in;
  assign Rout      = ctrl.r_out;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit.
//
// Each record describes one clock cycle:
//   - inputs (IR, BranchMet, Stop), applied at the negedge
//   - the expected strobe word and alu_op for the state occupied in that cycle
//
// The strobe word layout is local to this bench.

module tb_control_unit;
  import cu_pkg::*;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic [31:0] IR = '0;
  logic        BranchMet = 1'b0;
  logic        Stop = 1'b0;

  logic Run, PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, BAout, Cout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONIn;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;
  logic [ALUOPW-1:0] alu_op;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .BranchMet(BranchMet), .Stop(Stop),
    .Run(Run), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .BAout(BAout), .Cout(Cout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONIn(CONIn), .IncPC(IncPC),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .alu_op(alu_op)
  );

  always #5 Clock = ~Clock;

  localparam logic [27:0] S_RUN     = 28'h1 << 0;
  localparam logic [27:0] S_PCOUT   = 28'h1 << 1;
  localparam logic [27:0] S_ZHIOUT  = 28'h1 << 2;
  localparam logic [27:0] S_ZLOWOUT = 28'h1 << 3;
  localparam logic [27:0] S_MDROUT  = 28'h1 << 4;
  localparam logic [27:0] S_HIOUT   = 28'h1 << 5;
  localparam logic [27:0] S_LOOUT   = 28'h1 << 6;
  localparam logic [27:0] S_INPOUT  = 28'h1 << 7;
  localparam logic [27:0] S_BAOUT   = 28'h1 << 8;
  localparam logic [27:0] S_COUT    = 28'h1 << 9;
  localparam logic [27:0] S_PCIN    = 28'h1 << 10;
  localparam logic [27:0] S_MARIN   = 28'h1 << 11;
  localparam logic [27:0] S_MDRIN   = 28'h1 << 12;
  localparam logic [27:0] S_IRIN    = 28'h1 << 13;
  localparam logic [27:0] S_YIN     = 28'h1 << 14;
  localparam logic [27:0] S_ZIN     = 28'h1 << 15;
  localparam logic [27:0] S_HIIN    = 28'h1 << 16;
  localparam logic [27:0] S_LOIN    = 28'h1 << 17;
  localparam logic [27:0] S_OUTPIN  = 28'h1 << 18;
  localparam logic [27:0] S_CONIN   = 28'h1 << 19;
  localparam logic [27:0] S_INCPC   = 28'h1 << 20;
  localparam logic [27:0] S_READ    = 28'h1 << 21;
  localparam logic [27:0] S_WRITE   = 28'h1 << 22;
  localparam logic [27:0] S_GRA     = 28'h1 << 23;
  localparam logic [27:0] S_GRB     = 28'h1 << 24;
  localparam logic [27:0] S_GRC     = 28'h1 << 25;
  localparam logic [27:0] S_RIN     = 28'h1 << 26;
  localparam logic [27:0] S_ROUT    = 28'h1 << 27;
  localparam logic [27:0] S_NONE    = 28'h0;

  localparam logic [27:0] F0 = S_RUN | S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
  localparam logic [27:0] F1 = S_RUN | S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [27:0] F2 = S_RUN | S_MDROUT | S_IRIN;

  localparam logic [31:0] IR_ANDI = 32'h590FFFFB;  // andi R2,R1,-5
  localparam logic [31:0] IR_LD   = 32'h00800004;  // ld R1,4
  localparam logic [31:0] IR_BR   = 32'h90000000;
  localparam logic [31:0] IR_JAL  = 32'hA0000000;
  localparam logic [31:0] IR_ADD  = 32'h18000000;
  localparam logic [31:0] IR_SUB  = 32'h20000000;
  localparam logic [31:0] IR_MUL  = 32'h78000000;
  localparam logic [31:0] IR_HALT = 32'hD0000000;

  typedef struct {
    logic [31:0] ir;
    logic        bm;
    logic        stop;
    logic [27:0] strobes;
    logic [3:0]  alu;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [31:0] act;
  always_comb begin
    act = '0;
    act[0]  = Run;       act[1]  = PCout;     act[2]  = Zhiout;  act[3]  = Zlowout;
    act[4]  = MDRout;    act[5]  = HIout;     act[6]  = LOout;   act[7]  = InPortout;
    act[8]  = BAout;     act[9]  = Cout;      act[10] = PCin;    act[11] = MARin;
    act[12] = MDRin;     act[13] = IRin;      act[14] = Yin;     act[15] = Zin;
    act[16] = HIin;      act[17] = LOin;      act[18] = OutPortin; act[19] = CONIn;
    act[20] = IncPC;     act[21] = Read;      act[22] = Write;   act[23] = Gra;
    act[24] = Grb;       act[25] = Grc;       act[26] = Rin;     act[27] = Rout;
    act[31:28] = alu_op;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got alu/strobes %h, expected %h", name, got, exp);
    else
      n_pass++;
  endtask

  task automatic push(input logic [31:0] ir, input logic bm, input logic stop,
                      input logic [27:0] s, input logic [3:0] alu);
    vec_t v;
    v.ir = ir; v.bm = bm; v.stop = stop; v.strobes = s; v.alu = alu;
    tbl.push_back(v);
  endtask

  // One cycle: drive at negedge (Clear released), check the current state's outputs.
  task automatic step(input string name, input logic [31:0] ir, input logic bm,
                      input logic stop, input logic [27:0] s, input logic [3:0] alu);
    @(negedge Clock);
    Clear = 1'b1; IR = ir; BranchMet = bm; Stop = stop;
    #1;
    check(name, act, {alu, s});
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i])
      step($sformatf("%s_row%0d", tag, i), tbl[i].ir, tbl[i].bm, tbl[i].stop,
           tbl[i].strobes, tbl[i].alu);
    tbl.delete();
  endtask

  task automatic push_fetch(input logic [31:0] ir, input logic bm);
    push(ir, bm, 1'b0, F0, ALU_ADD);
    push(ir, bm, 1'b0, F1, ALU_ADD);
    push(ir, bm, 1'b0, F2, ALU_ADD);
  endtask

  initial begin
    // Clear held low for two cycles.
    @(negedge Clock); #1; check("clear_low_c0", act, {ALU_ADD, S_NONE});
    @(negedge Clock); #1; check("clear_low_c1", act, {ALU_ADD, S_NONE});

    // ---------------- table 1 ----------------
    push(IR_ANDI, 1'b0, 1'b0, S_NONE, ALU_ADD);  // RESET after release
    // andi
    push_fetch(IR_ANDI, 1'b0);
    push(IR_ANDI, 1'b0, 1'b0, S_RUN | S_GRB | S_ROUT | S_YIN, ALU_ADD);
    push(IR_ANDI, 1'b0, 1'b0, S_RUN | S_COUT | S_ZIN, ALU_AND);
    push(IR_ANDI, 1'b0, 1'b0, S_RUN | S_ZLOWOUT | S_GRA | S_RIN, ALU_ADD);
    // ld
    push_fetch(IR_LD, 1'b0);
    push(IR_LD, 1'b0, 1'b0, S_RUN | S_GRB | S_BAOUT | S_YIN, ALU_ADD);
    push(IR_LD, 1'b0, 1'b0, S_RUN | S_COUT | S_ZIN, ALU_ADD);
    push(IR_LD, 1'b0, 1'b0, S_RUN | S_ZLOWOUT | S_MARIN, ALU_ADD);
    push(IR_LD, 1'b0, 1'b0, S_RUN | S_READ | S_MDRIN, ALU_ADD);
    push(IR_LD, 1'b0, 1'b0, S_RUN | S_MDROUT | S_GRA | S_RIN, ALU_ADD);
    // br, not taken
    push_fetch(IR_BR, 1'b0);
    push(IR_BR, 1'b0, 1'b0, S_RUN | S_GRA | S_ROUT | S_CONIN, ALU_ADD);
    push(IR_BR, 1'b0, 1'b0, S_RUN | S_PCOUT | S_YIN, ALU_ADD);
    push(IR_BR, 1'b0, 1'b0, S_RUN | S_COUT | S_ZIN, ALU_ADD);
    push(IR_BR, 1'b0, 1'b0, S_RUN, ALU_ADD);
    // br, taken
    push_fetch(IR_BR, 1'b1);
    push(IR_BR, 1'b1, 1'b0, S_RUN | S_GRA | S_ROUT | S_CONIN, ALU_ADD);
    push(IR_BR, 1'b1, 1'b0, S_RUN | S_PCOUT | S_YIN, ALU_ADD);
    push(IR_BR, 1'b1, 1'b0, S_RUN | S_COUT | S_ZIN, ALU_ADD);
    push(IR_BR, 1'b1, 1'b0, S_RUN | S_ZLOWOUT | S_PCIN, ALU_ADD);
    // jal
    push_fetch(IR_JAL, 1'b0);
    push(IR_JAL, 1'b0, 1'b0, S_RUN | S_PCOUT | S_GRB | S_RIN, ALU_ADD);
    push(IR_JAL, 1'b0, 1'b0, S_RUN | S_GRA | S_ROUT | S_PCIN, ALU_ADD);
    // add with Stop only in T4: ignored
    push_fetch(IR_ADD, 1'b0);
    push(IR_ADD, 1'b0, 1'b0, S_RUN | S_GRB | S_ROUT | S_YIN, ALU_ADD);
    push(IR_ADD, 1'b0, 1'b1, S_RUN | S_GRC | S_ROUT | S_ZIN, ALU_ADD);
    push(IR_ADD, 1'b0, 1'b0, S_RUN | S_ZLOWOUT | S_GRA | S_RIN, ALU_ADD);
    // sub with Stop held through T5: halts
    push_fetch(IR_SUB, 1'b0);
    push(IR_SUB, 1'b0, 1'b0, S_RUN | S_GRB | S_ROUT | S_YIN, ALU_ADD);
    push(IR_SUB, 1'b0, 1'b1, S_RUN | S_GRC | S_ROUT | S_ZIN, ALU_SUB);
    push(IR_SUB, 1'b0, 1'b1, S_RUN | S_ZLOWOUT | S_GRA | S_RIN, ALU_ADD);
    push(IR_SUB, 1'b0, 1'b0, S_NONE, ALU_ADD);  // HALT
    run_table("t1");

    // HALT holds for 10 cycles whatever Stop/BranchMet do.
    for (int i = 0; i < 10; i++)
      step($sformatf("halt_hold%0d", i), IR_LD, i[0], ~i[0], S_NONE, ALU_ADD);

    // Clear out of HALT, then abort ld mid-T6.
    @(negedge Clock); Clear = 1'b0; #1;
    check("clear_from_halt", act, {ALU_ADD, S_NONE});
    step("ld2_reset", IR_LD, 1'b0, 1'b0, S_NONE, ALU_ADD);
    step("ld2_t0", IR_LD, 1'b0, 1'b0, F0, ALU_ADD);
    step("ld2_t1", IR_LD, 1'b0, 1'b0, F1, ALU_ADD);
    step("ld2_t2", IR_LD, 1'b0, 1'b0, F2, ALU_ADD);
    step("ld2_t3", IR_LD, 1'b0, 1'b0, S_RUN | S_GRB | S_BAOUT | S_YIN, ALU_ADD);
    step("ld2_t4", IR_LD, 1'b0, 1'b0, S_RUN | S_COUT | S_ZIN, ALU_ADD);
    step("ld2_t5", IR_LD, 1'b0, 1'b0, S_RUN | S_ZLOWOUT | S_MARIN, ALU_ADD);
    step("ld2_t6", IR_LD, 1'b0, 1'b0, S_RUN | S_READ | S_MDRIN, ALU_ADD);
    #1; Clear = 1'b0; #1;
    check("clear_mid_t6", act, {ALU_ADD, S_NONE});

    // ---------------- table 2: mul, then halt opcode ----------------
    push(IR_MUL, 1'b0, 1'b0, S_NONE, ALU_ADD);  // RESET after release
    push_fetch(IR_MUL, 1'b0);
`ifdef MUL_DIV_EN
    push(IR_MUL, 1'b0, 1'b0, S_RUN | S_GRA | S_ROUT | S_YIN, ALU_ADD);
    push(IR_MUL, 1'b0, 1'b0, S_RUN | S_GRB | S_ROUT | S_ZIN, ALU_MUL);
    push(IR_MUL, 1'b0, 1'b0, S_RUN | S_ZLOWOUT | S_LOIN, ALU_ADD);
    push(IR_MUL, 1'b0, 1'b0, S_RUN | S_ZHIOUT | S_HIIN, ALU_ADD);
`else
    push(IR_MUL, 1'b0, 1'b0, S_RUN, ALU_ADD);   // executes as nop
`endif
    push_fetch(IR_HALT, 1'b0);
    push(IR_HALT, 1'b0, 1'b0, S_RUN, ALU_ADD);
    push(IR_HALT, 1'b0, 1'b0, S_NONE, ALU_ADD);  // HALT
    push(IR_LD, 1'b0, 1'b0, S_NONE, ALU_ADD);
    run_table("t2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
